// File: rtl/serial_parity_tx_pkg.sv
// Shared types and constants for the serial parity transmitter.
// The optional break feature is enabled by defining SERIAL_TX_BREAK_EN.
package serial_parity_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int FRAME_DATA_BITS = 8;

  // Parity-select encoding for the EVENP parameter.
  localparam bit PARITY_EVEN = 1'b1;
  localparam bit PARITY_ODD  = 1'b0;

endpackage

// File: rtl/serial_parity_tx_if.sv
// Byte handshake plus serial line bundle for serial_parity_tx.
// With SERIAL_TX_BREAK_EN defined the bundle also carries the brk request.
interface serial_parity_tx_if;
  import serial_parity_tx_pkg::*;

  logic [FRAME_DATA_BITS-1:0] data_in;
  logic                       valid;
  logic                       ready;
  logic                       tx;
  logic                       busy;
  logic                       done;
`ifdef SERIAL_TX_BREAK_EN
  logic                       brk;

  modport master (output data_in, valid, brk, input ready, tx, busy, done);
  modport slave  (input data_in, valid, brk, output ready, tx, busy, done);
`else
  modport master (output data_in, valid, input ready, tx, busy, done);
  modport slave  (input data_in, valid, output ready, tx, busy, done);
`endif

endinterface

// File: rtl/serial_parity_tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while not cleared, tick on terminal count.
// Shared by all builds (SERIAL_TX_BREAK_EN does not affect this block).
module serial_parity_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TERMINAL = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] count_reg;
  logic [TW-1:0] count_next;

  assign tick = !clear && (count_reg == TERMINAL);

  always_comb begin
    count_next = count_reg + TW'(1);
    if (clear || tick) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/serial_parity_tx.sv
// Byte serializer: start bit, 8 data bits LSB first, parity, STOP_BITS stop bits.
// Defining SERIAL_TX_BREAK_EN adds a brk request that holds the line low while idle.
module serial_parity_tx
  import serial_parity_tx_pkg::*;
#(
  parameter bit EVENP        = PARITY_EVEN,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input logic               clk,
  input logic               rst_n,
  serial_parity_tx_if.slave bus
);

  localparam logic [2:0] LAST_DATA_IDX = 3'(FRAME_DATA_BITS - 1);
  localparam logic       LAST_STOP_IDX = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  state_t                     state_reg, state_next;
  logic [FRAME_DATA_BITS-1:0] shift_reg, shift_next;
  logic                       parity_reg, parity_next;
  logic [2:0]                 bit_idx_reg, bit_idx_next;
  logic                       stop_idx_reg, stop_idx_next;
  logic                       tx_reg, tx_next;
  logic                       done_reg, done_next;
  logic                       brk_reg, brk_next;

  logic tick;
  logic timer_clear;
  logic accept;
  logic brk_req;

`ifdef SERIAL_TX_BREAK_EN
  assign brk_req = bus.brk;
`else
  assign brk_req = 1'b0;
`endif

  assign bus.ready = (state_reg == IDLE) && !brk_reg;
  assign bus.busy  = (state_reg != IDLE);
  assign bus.tx    = tx_reg;
  assign bus.done  = done_reg;

  assign accept      = bus.valid && bus.ready;
  // The timer is held at zero in IDLE so the start bit gets a full period.
  assign timer_clear = (state_reg == IDLE);

  serial_parity_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (timer_clear),
    .tick  (tick)
  );

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    bit_idx_next  = bit_idx_reg;
    stop_idx_next = stop_idx_reg;
    tx_next       = tx_reg;
    done_next     = 1'b0;
    brk_next      = 1'b0;

    unique case (state_reg)
      IDLE: begin
        brk_next = brk_req && !accept;
        tx_next  = !brk_req;
        if (accept) begin
          shift_next  = bus.data_in;
          parity_next = (EVENP == PARITY_EVEN) ? ^bus.data_in : ~^bus.data_in;
          state_next  = START;
          tx_next     = 1'b0;
        end
      end

      START: begin
        if (tick) begin
          state_next   = DATA;
          bit_idx_next = '0;
          tx_next      = shift_reg[0];
        end
      end

      DATA: begin
        if (tick) begin
          if (bit_idx_reg == LAST_DATA_IDX) begin
            state_next = PARITY;
            tx_next    = parity_reg;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            shift_next   = {1'b0, shift_reg[FRAME_DATA_BITS-1:1]};
            tx_next      = shift_reg[1];
          end
        end
      end

      PARITY: begin
        if (tick) begin
          state_next    = STOP;
          stop_idx_next = 1'b0;
          tx_next       = 1'b1;
        end
      end

      STOP: begin
        tx_next = 1'b1;
        if (tick) begin
          if (stop_idx_reg == LAST_STOP_IDX) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            stop_idx_next = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      tx_reg       <= 1'b1;
      done_reg     <= 1'b0;
      brk_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      bit_idx_reg  <= bit_idx_next;
      stop_idx_reg <= stop_idx_next;
      tx_reg       <= tx_next;
      done_reg     <= done_next;
      brk_reg      <= brk_next;
    end
  end

endmodule
